// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU (AND/OR/ADD/SUB/SLT/XOR/NOR) with registered result and flags.
// Define ALU_SEQ_MUL_EN to build op 111 as an iterative unsigned shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
`ifdef ALU_SEQ_MUL_EN
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     step;
`else
    typedef enum logic [1:0] {S_IDLE, S_DONE} state_t;
`endif
    state_t           state_q, state_d;
    logic             valid_q, valid_d, carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             accept, sub;
    logic [WIDTH-1:0] bb, alu_res;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v;

    assign in_ready  = !rst && (state_q == S_IDLE || (state_q == S_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign result    = result_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

    // ADD and SUB share one adder; SUB is a + ~b + 1
    always_comb begin
        sub = op == 3'b011;
        bb  = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub | (op == 3'b010 && carry_in)};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            3'b000: alu_res = a & b;
            3'b001: alu_res = a | b;
            3'b010, 3'b011: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b100: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            3'b101: alu_res = a ^ b;
            3'b110: alu_res = ~(a | b);
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    assign step = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
`endif

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
`ifdef ALU_SEQ_MUL_EN
        cnt_d    = cnt_q;
        a_d      = a_q;
        prod_d   = prod_q;
`endif
        if (state_q == S_DONE && out_ready) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (op == 3'b111) begin
                state_d = S_MUL;
                valid_d = 1'b0;
                a_d     = a;
                prod_d  = {{WIDTH{1'b0}}, b};
                cnt_d   = '0;
            end else
`endif
            begin
                state_d  = S_DONE;
                valid_d  = 1'b1;
                result_d = alu_res;
                carry_d  = alu_c;
                ovf_d    = alu_v;
                zero_d   = alu_res == '0;
            end
        end
`ifdef ALU_SEQ_MUL_EN
        // low half of prod holds the unconsumed multiplier bits, shifted out LSB first
        if (state_q == S_MUL) begin
            prod_d = {step, prod_q[WIDTH-1:1]};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d  = S_DONE;
                valid_d  = 1'b1;
                cnt_d    = '0;
                result_d = prod_d[WIDTH-1:0];
                carry_d  = |prod_d[2*WIDTH-1:WIDTH];
                ovf_d    = 1'b0;
                zero_d   = prod_d[WIDTH-1:0] == '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q    <= '0;
            a_q      <= '0;
            prod_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
`ifdef ALU_SEQ_MUL_EN
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            prod_q   <= prod_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  op = '0;
    logic        carry_in = 1'b0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out, overflow, zero;
    int          total = 0, bad = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    always #5 clk = ~clk;

    // returns {zero, overflow, carry, result}
    function automatic logic [34:0] model(logic [2:0] xop, logic [31:0] xa, logic [31:0] xb, logic xc);
        longint      sa = longint'($signed(xa));
        longint      sb = longint'($signed(xb));
        longint      s;
        logic [63:0] u;
        logic [31:0] r = '0;
        logic        c = 1'b0, v = 1'b0;
        case (xop)
            3'd0: r = xa & xb;
            3'd1: r = xa | xb;
            3'd2: begin
                u = 64'(xa) + 64'(xb) + 64'(xc);
                r = u[31:0];
                c = u[32];
                s = sa + sb + longint'(xc);
                v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'd3: begin
                r = xa - xb;
                c = xa >= xb;
                s = sa - sb;
                v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: r = xa ^ xb;
            3'd6: r = ~(xa | xb);
            default: begin
`ifdef ALU_SEQ_MUL_EN
                u = 64'(xa) * 64'(xb);
                r = u[31:0];
                c = |u[63:32];
`else
                r = '0;
`endif
            end
        endcase
        return {r == 32'd0, v, c, r};
    endfunction

    function automatic int exp_lat(logic [2:0] xop);
`ifdef ALU_SEQ_MUL_EN
        return xop == 3'd7 ? 32 : 0;
`else
        return 0;
`endif
    endfunction

    // One op from IDLE; optionally leaves the result unconsumed in DONE.
    task automatic send(input logic [2:0] xop, input logic [31:0] xa, input logic [31:0] xb,
                        input logic xc, input bit consume);
        logic [34:0] e;
        logic [31:0] held;
        int n, lat;
        logic rdy_seen;
        e = model(xop, xa, xb, xc);
        op = xop; a = xa; b = xb; carry_in = xc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL accept_wait in_ready=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom); carry_in = 1'($urandom);
        out_ready = 1'($urandom);
        lat = 0; rdy_seen = 1'b0;
        while (out_valid !== 1'b1 && lat < 100) begin
            rdy_seen |= in_ready;
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
        total++;
        if (lat != exp_lat(xop)) begin bad++; $display("FAIL latency op=%0d got=%0d want=%0d", xop, lat, exp_lat(xop)); end
        total++;
        if (rdy_seen !== 1'b0) begin bad++; $display("FAIL busy_in_ready op=%0d got=%b want=0", xop, rdy_seen); end
        total++;
        if ({zero, overflow, carry_out, result} !== e)
        begin
            bad++;
            $display("FAIL result op=%0d a=%h b=%h cin=%b got z/v/c/r=%b/%b/%b/%h want=%b/%b/%b/%h",
                     xop, xa, xb, xc, zero, overflow, carry_out, result, e[34], e[33], e[32], e[31:0]);
        end
        if (consume) begin
            held = result;
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                total++;
                if (out_valid !== 1'b1 || result !== held) begin
                    bad++; $display("FAIL hold valid=%b got=%h want=%h", out_valid, result, held);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL consume out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({out_valid, result, carry_out, overflow, zero} !== 36'd0) begin
            bad++; $display("FAIL reset_outputs valid=%b result=%h c=%b v=%b z=%b want all 0",
                            out_valid, result, carry_out, overflow, zero);
        end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_directed;
        send(3'd2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
        send(3'd2, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b1);
        send(3'd3, 32'h80000000, 32'h00000001, 1'b1, 1'b1);
        send(3'd3, 32'h00000001, 32'h00000002, 1'b0, 1'b1);
        send(3'd4, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1);
        send(3'd4, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1);
        send(3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b1);
        send(3'd1, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b1);
        send(3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b1);
        send(3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b1);
        send(3'd7, 32'h00010000, 32'h00010000, 1'b0, 1'b1);
        send(3'd7, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic [31:0] pool [6];
        logic [31:0] xa, xb;
        for (int i = 0; i < 40; i++) begin
            pool = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, $urandom};
            xa = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            xb = ($urandom_range(0, 2) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            send(3'($urandom_range(0, 7)), xa, xb, 1'($urandom), 1'b1);
        end
    endtask

    task automatic test_back_to_back;
        logic [34:0] e;
        logic [31:0] held;
        logic [2:0]  xop;
        logic [31:0] xa, xb;
        logic        xc;
        send(3'd3, 32'h12345678, 32'h00000078, 1'b0, 1'b0);
        held = result;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0) begin
                bad++; $display("FAIL backpressure valid=%b in_ready=%b got=%h want=%h",
                                out_valid, in_ready, result, held);
            end
        end
        for (int i = 0; i < 8; i++) begin
            xop = 3'($urandom_range(0, 6)); xa = $urandom; xb = $urandom; xc = 1'($urandom);
            e = model(xop, xa, xb, xc);
            op = xop; a = xa; b = xb; carry_in = xc; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            total++;
            if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready i=%0d got=%b want=1", i, in_ready); end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || {zero, overflow, carry_out, result} !== e) begin
                bad++; $display("FAIL b2b_result i=%0d op=%0d valid=%b got=%h want=%h",
                                i, xop, out_valid, {zero, overflow, carry_out, result}, e);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain valid=%b want=0", out_valid); end
    endtask

    task automatic test_abort;
        send(3'd2, 32'h00000005, 32'h00000003, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0) begin
            bad++; $display("FAIL abort_done valid=%b result=%h want 0/0", out_valid, result);
        end
        rst = 1'b0;
        op = 3'd7; a = 32'h00012345; b = 32'h0000ABCD; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0) begin
            bad++; $display("FAIL abort_mul valid=%b result=%h want 0/0", out_valid, result);
        end
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_release in_ready=%b want=1", in_ready); end
        repeat (40) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0) begin
            bad++; $display("FAIL abort_stale valid=%b result=%h want 0/0", out_valid, result);
        end
        send(3'd1, 32'h0000000F, 32'h000000F0, 1'b0, 1'b1);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 32-bit combinational AND/OR/ADD ALU. Accepts one operation per valid/ready transfer, registers the result together with zero, carry and overflow flags, and holds it until the consumer takes it. Adds SUB, SLT, XOR and NOR, plus an optional iterative shift-add multiplier. Sits between the datapath operand registers and the writeback stage.

## Interface

- `WIDTH`, default 32, operand and result width (≥ 2).
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand/opcode bundle valid.
- `in_ready`  out  1  block can accept a bundle this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 XOR, 110 NOR, 111 MUL.
- `carry_in`  in  1  carry into ADD; ignored by every other op.
- `out_valid`  out  1  result and flags valid.
- `out_ready`  in  1  consumer takes result this cycle.
- `result`  out  WIDTH  registered result.
- `carry_out`  out  1  registered carry flag.
- `overflow`  out  1  registered signed-overflow flag.
- `zero`  out  1  registered, 1 when `result` == 0.

## Operation

- States: IDLE, MUL, DONE. Reset state is IDLE.
- Accept occurs when `in_valid && in_ready`. `a`, `b`, `op` and `carry_in` are captured at accept, so later changes to these inputs have no effect.
- `in_ready` = (state == IDLE) || (state == DONE && `out_ready`), forced 0 while `rst` = 1.
- Single-cycle ops (000–110): on accept, compute and load the output registers, then go to DONE.
- ADD: {carry_out, result} = a + b + carry_in. overflow = signed overflow.
- SUB: a + ~b + 1. carry_out = 1 means no borrow (a ≥ b unsigned). overflow = signed overflow.
- SLT: result = signed(a) < signed(b) ? 1 : 0, zero-extended. carry_out = 0, overflow = 0.
- AND, OR, XOR, NOR: bitwise. carry_out = 0, overflow = 0.
- MUL: unsigned shift-add over a 2·WIDTH accumulator with an iteration counter of $clog2(WIDTH)+1 bits. One multiplier bit is processed per cycle in MUL state.
  - After the WIDTH-th iteration, load result = low WIDTH bits and carry_out = (high WIDTH bits ≠ 0), with overflow = 0. Then go to DONE.
- DONE: outputs are held stable while `out_valid` = 1 and `out_ready` = 0.
  - On `out_ready` = 1 with no new accept, go to IDLE and clear `out_valid`.
  - On `out_ready` = 1 with a simultaneous accept, the new op starts that same edge with no bubble.
- `zero` is always derived from the loaded result, including for MUL and SLT.

## Timing

- Reset values: `out_valid` 0, `result` 0, `carry_out` 0, `overflow` 0, `zero` 0. State is IDLE and the counter is 0. `in_ready` is 1 from the first cycle after `rst` deasserts.
- Single-cycle op accepted at edge N: `out_valid` = 1 from edge N; peak throughput is 1 op/cycle.
- MUL accepted at edge N: `in_ready` = 0 for cycles N+1 … N+WIDTH. `out_valid` rises at edge N+WIDTH.
- `rst` mid-MUL or in DONE: abort at that edge. No partial result is ever presented.
- `out_ready` is ignored while `out_valid` = 0.

## Configuration

- `ALU_SEQ_MUL_EN` defined: MUL state, counter and accumulator are compiled in, and op 111 behaves as above.
- `ALU_SEQ_MUL_EN` undefined: the MUL state and its logic are absent. Op 111 completes as a single-cycle op with result 0, zero 1, carry_out 0, overflow 0.

## Test plan

- ADD, WIDTH=32: a=0xFFFFFFFF, b=0x00000001, carry_in=0. Required: result 0x00000000, carry_out 1, zero 1, overflow 0, `out_valid` at the accept edge.
- SUB: a=0x80000000, b=0x00000001 gives 0x7FFFFFFF with overflow 1 and carry_out 1. SLT: a=0xFFFFFFFF, b=0x00000001 gives 0x00000001.
- Logic ops: a=0xF0F0F0F0, b=0xFF00FF00. AND gives 0xF000F000, OR 0xFFF0FFF0, XOR 0x0FF00FF0, NOR 0x000F000F. All with carry_out 0 and overflow 0.
- MUL (macro on): 0x00010000 × 0x00010000 gives result 0, carry_out 1, zero 1, exactly 32 cycles after accept, with `in_ready` = 0 throughout. 0x0000FFFF × 0x0000FFFF gives 0xFFFE0001 with carry_out 0. With the macro off, the same op gives result 0 on the next edge.
- Backpressure: hold `out_ready` = 0 for 5 cycles. `result` and flags stay stable and `in_ready` stays 0. Then assert `out_ready` with `in_valid` set on the same cycle: the new result appears on the next edge.
- Assert `rst` at MUL iteration 10. Required: on the next cycle `out_valid` = 0 and result 0, and after release `in_ready` = 1 with no stale result.
